// File: rtl/tmr_count_if.sv
// Peripheral bus between the CPU-side master and the interval timer:
// single-wait-state stb/ack cycles plus the timer's level interrupt.
interface tmr_count_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;

  modport master (
    output stb, we, addr, data_in,
    input  data_out, ack, irq
  );

  modport slave (
    input  stb, we, addr, data_in,
    output data_out, ack, irq
  );
endinterface

// File: rtl/tmr_count.sv
// Programmable interval timer: 32-bit down-counter reloading from a divisor,
// sticky expired flag, level interrupt gated by an enable bit.
module tmr_count #(
  parameter logic [31:0] DIV_INIT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  tmr_count_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_DIV  = 2'd1,
    REG_CNT  = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_e;

  logic [31:0] divisor;
  logic [31:0] counter;
  logic        expired;
  logic        ien;
  logic        ack_q;
  logic [31:0] rdata_q;

  reg_sel_e    sel;
  logic        access;
  logic        div_wr;
  logic        ctrl_wr;
  logic        wrap;
  logic [31:0] counter_nxt;
  logic [31:0] rdata_nxt;

  assign sel    = reg_sel_e'(bus.addr);
  // An access commits on the edge where stb is seen without a pending ack.
  assign access = bus.stb & ~ack_q;

  // NOTE: every signal gets a default before the case/if tree so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    div_wr      = 1'b0;
    ctrl_wr     = 1'b0;
    wrap        = 1'b0;
    counter_nxt = counter;
    rdata_nxt   = '0;

    if (access && bus.we) begin
      div_wr  = (sel == REG_DIV);
      ctrl_wr = (sel == REG_CTRL);
    end

    if (div_wr) begin
      counter_nxt = bus.data_in;
    end else if (counter == 32'd0) begin
      counter_nxt = 32'd0;
    end else if (counter == 32'd1) begin
      counter_nxt = divisor;
      wrap        = 1'b1;
    end else begin
      counter_nxt = counter - 32'd1;
    end

    // Reads see register values from before this edge's update.
    unique case (sel)
      REG_CTRL: rdata_nxt = {30'd0, ien, expired};
      REG_DIV:  rdata_nxt = divisor;
      REG_CNT:  rdata_nxt = counter;
      REG_NONE: rdata_nxt = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_INIT;
      counter <= DIV_INIT;
      expired <= 1'b0;
      ien     <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus.stb & ~ack_q;
      counter <= counter_nxt;
      if (div_wr) divisor <= bus.data_in;
      if (ctrl_wr) ien <= bus.data_in[1];
      // A wrap on the same edge as a clearing CTRL write must not be lost.
      if (wrap)         expired <= 1'b1;
      else if (ctrl_wr) expired <= bus.data_in[0];
      if (access) rdata_q <= rdata_nxt;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_out = rdata_q;
  assign bus.irq      = expired & ien;

endmodule

// File: tb/tb_tmr_count.sv
// Directed bench for tmr_count with DIV_INIT = 5: reset, counting, interrupt,
// divisor changes, wrap-vs-clear priority, back-to-back and async reset.
module tb_tmr_count;

  localparam logic [31:0] DIV_INIT = 32'd5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] rd_data;
  logic        ack_irq;

  tmr_count_if bus ();

  tmr_count #(.DIV_INIT(DIV_INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on falling edges. Every task starts
  // and ends just after a falling edge, so the next rising edge is "e1".
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated access: access edge is the first rising edge, ack edge the second.
  task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.stb     = 1'b1;
    bus.we      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b1) begin
      failures++;
      $display("FAIL bus_ack addr=%0d got=%b expected=1", a, bus.ack);
    end
    rd_data = bus.data_out;
    ack_irq = bus.irq;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Held in reset: all outputs zero.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || bus.data_out !== 32'd0 || bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b data_out=%h irq=%b expected 0/0/0",
               bus.ack, bus.data_out, bus.irq);
    end
    reset_dut();
    // Before e5 exp is still 0.
    wait_edges(4);
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL exp_before_e5 got=%h expected=0", rd_data);
    end
    reset_dut();
    // Before e6 exp has been set by the wrap at e5; ien=0 keeps irq low.
    wait_edges(5);
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd1 || ack_irq !== 1'b0) begin
      failures++;
      $display("FAIL exp_after_e5 got=%h irq=%b expected=1 irq=0", rd_data, ack_irq);
    end
    // CNT sampled at e1,e4,e7,e10,e13 covers every phase of the period-5 cycle.
    reset_dut();
    begin
      logic [31:0] exp_cnt [5];
      exp_cnt = '{32'd5, 32'd2, 32'd4, 32'd1, 32'd3};
      for (int i = 0; i < 5; i++) begin
        bus_op(1'b0, 2'd2, '0);
        checks++;
        if (rd_data !== exp_cnt[i]) begin
          failures++;
          $display("FAIL cnt_cycle[%0d] got=%0d expected=%0d", i, rd_data, exp_cnt[i]);
        end
        wait_edges(1);
      end
    end
  endtask

  task automatic test_irq();
    reset_dut();
    bus_op(1'b1, 2'd0, 32'h2);          // e1: ien=1
    wait_edges(3);                      // e3..e5, wrap at e5
    checks++;
    if (bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_after_wrap got=%b expected=1", bus.irq);
    end
    bus_op(1'b0, 2'd0, '0);             // e6
    checks++;
    if (rd_data !== 32'h3) begin
      failures++;
      $display("FAIL ctrl_read_irq got=%h expected=3", rd_data);
    end
    bus_op(1'b1, 2'd0, 32'h2);          // e8: clear exp, irq low in ack cycle
    checks++;
    if (ack_irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear_ack_cycle got=%b expected=0", ack_irq);
    end
  endtask

  task automatic test_div();
    reset_dut();
    bus_op(1'b1, 2'd1, 32'd3);          // e1: divisor=counter=3
    bus_op(1'b0, 2'd2, '0);             // e3
    checks++;
    if (rd_data !== 32'd2) begin
      failures++;
      $display("FAIL cnt_after_div3 got=%0d expected=2", rd_data);
    end
    bus_op(1'b0, 2'd0, '0);             // e5: first wrap landed on e4
    checks++;
    if (rd_data !== 32'd1) begin
      failures++;
      $display("FAIL exp_first_wrap_div3 got=%h expected=1", rd_data);
    end
    bus_op(1'b0, 2'd2, '0);             // e7
    checks++;
    if (rd_data !== 32'd1) begin
      failures++;
      $display("FAIL cnt_div3_e7 got=%0d expected=1", rd_data);
    end
    bus_op(1'b0, 2'd2, '0);             // e9: wrap at e7 reloaded 3
    checks++;
    if (rd_data !== 32'd2) begin
      failures++;
      $display("FAIL cnt_div3_e9 got=%0d expected=2", rd_data);
    end
    bus_op(1'b0, 2'd1, '0);
    checks++;
    if (rd_data !== 32'd3) begin
      failures++;
      $display("FAIL div_readback got=%0d expected=3", rd_data);
    end
    // Divisor 0 freezes the counter; exp is left alone either way.
    bus_op(1'b1, 2'd1, 32'd0);
    bus_op(1'b1, 2'd0, 32'd0);
    wait_edges(50);
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL div0_no_wrap got=%h expected=0", rd_data);
    end
    bus_op(1'b0, 2'd2, '0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL div0_cnt got=%0d expected=0", rd_data);
    end
    bus_op(1'b1, 2'd0, 32'd1);
    wait_edges(20);
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd1) begin
      failures++;
      $display("FAIL div0_exp_held got=%h expected=1", rd_data);
    end
  endtask

  task automatic test_wrap_wins();
    reset_dut();
    wait_edges(4);                      // counter = 1 before e5
    bus_op(1'b1, 2'd0, 32'h2);          // e5: clear exp + set ien, wrap wins
    checks++;
    if (ack_irq !== 1'b1) begin
      failures++;
      $display("FAIL wrap_wins_irq got=%b expected=1", ack_irq);
    end
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'h3) begin
      failures++;
      $display("FAIL wrap_wins_ctrl got=%h expected=3", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        w_v [4];
    logic [1:0]  a_v [4];
    logic [31:0] d_v [4];
    w_v = '{1'b1, 1'b1, 1'b0, 1'b0};
    a_v = '{2'd2, 2'd3, 2'd3, 2'd2};
    d_v = '{32'hDEAD, 32'hBEEF, 32'h0, 32'h0};
    reset_dut();
    bus.stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.we      = w_v[i];
      bus.addr    = a_v[i];
      bus.data_in = d_v[i];
      @(negedge clk);
      checks++;
      if (bus.ack !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ack_high[%0d] got=%b expected=1", i, bus.ack);
      end
      if (i == 2) begin
        checks++;
        if (bus.data_out !== 32'd0) begin
          failures++;
          $display("FAIL b2b_addr3_read got=%h expected=0", bus.data_out);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.data_out !== 32'd4) begin
          failures++;
          $display("FAIL b2b_cnt_read got=%0d expected=4", bus.data_out);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.ack !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ack_low[%0d] got=%b expected=0", i, bus.ack);
      end
    end
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    bus_op(1'b0, 2'd1, '0);
    checks++;
    if (rd_data !== 32'd5) begin
      failures++;
      $display("FAIL b2b_div_unchanged got=%0d expected=5", rd_data);
    end
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd1) begin
      failures++;
      $display("FAIL b2b_ctrl_unchanged got=%h expected=1", rd_data);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    bus_op(1'b1, 2'd1, 32'd7);
    bus_op(1'b1, 2'd0, 32'h3);
    bus.stb  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 2'd1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.ack !== 1'b1 || bus.irq !== 1'b1 || bus.data_out !== 32'd7) begin
      failures++;
      $display("FAIL pre_reset_state ack=%b irq=%b data_out=%0d expected 1/1/7",
               bus.ack, bus.irq, bus.data_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || bus.irq !== 1'b0 || bus.data_out !== 32'd0) begin
      failures++;
      $display("FAIL async_reset ack=%b irq=%b data_out=%h expected 0/0/0",
               bus.ack, bus.irq, bus.data_out);
    end
    bus.stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_op(1'b0, 2'd2, '0);
    checks++;
    if (rd_data !== DIV_INIT) begin
      failures++;
      $display("FAIL async_reset_cnt got=%0d expected=%0d", rd_data, DIV_INIT);
    end
    bus_op(1'b0, 2'd1, '0);
    checks++;
    if (rd_data !== DIV_INIT) begin
      failures++;
      $display("FAIL async_reset_div got=%0d expected=%0d", rd_data, DIV_INIT);
    end
    bus_op(1'b0, 2'd0, '0);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_ctrl got=%h expected=0", rd_data);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 2'd0;
    bus.data_in = '0;
    test_reset();
    test_irq();
    test_div();
    test_wrap_wins();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
